// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packet source: beat width and FSM state encoding.
package axis_pkg;
  localparam int AXIS_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/axis_pkt_master_if.sv
// AXI-Stream beat channel (tvalid/tdata/tlast/tready) with master and slave views.
interface axis_pkt_master_if;
  import axis_pkg::*;

  logic                   tvalid;
  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tlast;
  logic                   tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock circular byte FIFO with first-word fall-through head and occupancy count.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [AXIS_DATA_W-1:0] wdata,
  input  logic                   pop,
  output logic [AXIS_DATA_W-1:0] rdata,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AXIS_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axis_pkt_master.sv
// AXI-Stream packet source: buffers bytes, then emits pkt_len of them as one packet on start.
// Optional completed-packet counter enabled by defining AXIS_PKT_CNT_EN.
module axis_pkt_master
  import axis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                   m_axis_clk,
  input  logic                   m_axis_resetn,
  input  logic                   wr_en,
  input  logic [AXIS_DATA_W-1:0] wr_data,
  output logic                   wr_full,
  input  logic                   start,
  input  logic [LEN_W-1:0]       pkt_len,
  output logic                   busy,
  output logic                   done,
`ifdef AXIS_PKT_CNT_EN
  output logic [15:0]            pkt_count,
`endif
  axis_pkt_master_if.master      m_axis
);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

  state_t                 state;
  logic [LEN_W-1:0]       rem;
  logic                   tvalid;
  logic                   tlast;
  logic                   accept;
  logic                   empty;
  logic [LEN_W-1:0]       count;
  logic [AXIS_DATA_W-1:0] head;

  axis_sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (LEN_W)
  ) u_fifo (
    .clk    (m_axis_clk),
    .resetn (m_axis_resetn),
    .push   (wr_en),
    .wdata  (wr_data),
    .pop    (accept),
    .rdata  (head),
    .full   (wr_full),
    .empty  (empty),
    .count  (count)
  );

  assign accept        = tvalid & m_axis.tready & ~empty;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  // The head only moves on a pop, so tdata holds while tready is low.
  assign m_axis.tdata  = tvalid ? head : '0;

  always_ff @(posedge m_axis_clk) begin
    if (!m_axis_resetn) begin
      state  <= IDLE;
      rem    <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (pkt_len != '0) && (pkt_len <= count)) begin
            state  <= SEND;
            rem    <= pkt_len;
            tvalid <= 1'b1;
            tlast  <= (pkt_len == ONE);
            busy   <= 1'b1;
          end
        end
        SEND: begin
          if (accept) begin
            if (rem == ONE) begin
              state  <= IDLE;
              rem    <= '0;
              tvalid <= 1'b0;
              tlast  <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              rem   <= rem - 1'b1;
              tlast <= (rem == TWO);
            end
          end
        end
        default: begin
          state  <= IDLE;
          tvalid <= 1'b0;
          tlast  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_PKT_CNT_EN
  always_ff @(posedge m_axis_clk) begin
    if (!m_axis_resetn) begin
      pkt_count <= '0;
    end else if (done) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif
endmodule
